// File: rtl/alu_exec_if.sv
// Valid/ready bundle between operand fetch, the ALU execute stage and write-back.
// master: the side that issues ops and drains results (upstream + downstream).
// slave:  the execute stage itself.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered execute stage: single-cycle AND/OR/ADD/SUB/SLT plus an
// iterative shift-add multiplier returning the low WIDTH bits of a*b.
// Single-cycle ops complete on the accept edge; MUL spends WIDTH further
// cycles iterating and stalls upstream while it does.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_exec_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t state_p0;
  state_t state_nxt;

  // Output register stage
  logic [WIDTH-1:0] res_p0;
  logic             zero_p0;
  logic             vld_p0;

  // Multiplier working registers
  logic [WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0] mplier_p0;
  logic [WIDTH-1:0] acc_p0;
  logic [CNT_W-1:0] cnt_p0;

  logic             in_ready_c;
  logic             accept;
  logic             is_mul;
  logic             mul_last;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_nxt;

  // Single-cycle ALU. Reserved encodings (and MUL, which never takes this
  // path) yield zero so reserved ops complete with result=0, zero=1.
  function automatic logic [WIDTH-1:0] alu_calc(
    input logic [2:0]       f_op,
    input logic [WIDTH-1:0] f_a,
    input logic [WIDTH-1:0] f_b
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic                    lt;
    sa = f_a;
    sb = f_b;
    lt = (sa < sb);
    case (f_op)
      OP_AND:  alu_calc = f_a & f_b;
      OP_OR:   alu_calc = f_a | f_b;
      OP_ADD:  alu_calc = f_a + f_b;
      OP_SUB:  alu_calc = f_a - f_b;
      OP_SLT:  alu_calc = {{(WIDTH-1){1'b0}}, lt};
      default: alu_calc = '0;
    endcase
  endfunction

  // One shift-add step: add the multiplicand when the current multiplier
  // bit is set. Wraps mod 2^WIDTH, giving the low word of the product.
  function automatic logic [WIDTH-1:0] mul_step(
    input logic [WIDTH-1:0] f_acc,
    input logic [WIDTH-1:0] f_mcand,
    input logic             f_bit
  );
    mul_step = f_bit ? (f_acc + f_mcand) : f_acc;
  endfunction

  // Ready only in IDLE, out of reset, and when the output slot is free or
  // draining this cycle.
  assign in_ready_c = reset_n && (state_p0 == ST_IDLE) && (!vld_p0 || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign is_mul     = (bus.op == OP_MUL);
  assign mul_last   = (state_p0 == ST_MUL) && (cnt_p0 == CNT_W'(WIDTH - 1));
  assign alu_res    = alu_calc(bus.op, bus.a, bus.b);
  assign acc_nxt    = mul_step(acc_p0, mcand_p0, mplier_p0[0]);

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = vld_p0;
  assign bus.result    = res_p0;
  assign bus.zero      = zero_p0;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_p0 <= ST_IDLE;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // Next-state: enter MUL on a MUL accept, leave after the last iteration
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_IDLE: begin
        if (accept && is_mul) begin
          state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result/valid register and multiplier iteration
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p0    <= 1'b0;
      res_p0    <= '0;
      zero_p0   <= 1'b0;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
      acc_p0    <= '0;
      cnt_p0    <= '0;
    end else begin
      case (state_p0)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              // Old result (if any) transfers on this edge; nothing new yet.
              mcand_p0  <= bus.a;
              mplier_p0 <= bus.b;
              acc_p0    <= '0;
              cnt_p0    <= '0;
              vld_p0    <= 1'b0;
            end else begin
              res_p0  <= alu_res;
              zero_p0 <= (alu_res == '0);
              vld_p0  <= 1'b1;
            end
          end else if (vld_p0 && bus.out_ready) begin
            vld_p0 <= 1'b0;
          end
        end
        ST_MUL: begin
          acc_p0    <= acc_nxt;
          mcand_p0  <= mcand_p0 << 1;
          mplier_p0 <= mplier_p0 >> 1;
          cnt_p0    <= cnt_p0 + CNT_W'(1);
          if (mul_last) begin
            res_p0  <= acc_nxt;
            zero_p0 <= (acc_nxt == '0);
            vld_p0  <= 1'b1;
          end
        end
        default: begin
          vld_p0 <= 1'b0;
        end
      endcase
    end
  end

endmodule
